// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - data stack with TOS register, registered-read RAM spill and sticky errors
module stack_unit #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  output logic                  cmd_ready,
  output logic [WIDTH-1:0]      tos,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  err_overflow,
  output logic                  err_underflow,
  input  logic                  err_clr
);

  localparam int                  CAP_INT   = (1 << DEPTH_LOG2) + 1;
  localparam logic [DEPTH_LOG2:0] CAP       = CAP_INT[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] DEPTH_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] SP_ONE  = 1;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_REP  = 2'b10;
  localparam logic [1:0] OP_DUP  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_LOAD} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] sp_q, sp_d;
  logic [DEPTH_LOG2:0]   depth_q, depth_d;
  logic [WIDTH-1:0]      tos_q, tos_d;
  logic                  empty_q, full_q;
  logic                  ovf_q, ovf_d, unf_q, unf_d;

  logic [WIDTH-1:0]      mem [0:(1<<DEPTH_LOG2)-1];
  logic [WIDTH-1:0]      rd_q;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic                  accept;

  assign cmd_ready     = (state_q == S_IDLE) && !rst;
  assign accept        = cmd_valid && cmd_ready;
  assign tos           = tos_q;
  assign depth         = depth_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    depth_d  = depth_q;
    tos_d    = tos_q;
    ovf_d    = ovf_q & ~err_clr;
    unf_d    = unf_q & ~err_clr;
    mem_we   = 1'b0;
    // Address defaults to the entry under TOS so the read stays valid through RD_WAIT.
    mem_addr = sp_q - SP_ONE;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUSH: begin
              if (full_q) begin
                ovf_d = 1'b1;
              end else begin
                if (!empty_q) begin
                  mem_we   = 1'b1;
                  mem_addr = sp_q;
                  sp_d     = sp_q + SP_ONE;
                end
                tos_d   = cmd_data;
                depth_d = depth_q + DEPTH_ONE;
              end
            end
            OP_DUP: begin
              if (empty_q) begin
                unf_d = 1'b1;
              end else if (full_q) begin
                ovf_d = 1'b1;
              end else begin
                mem_we   = 1'b1;
                mem_addr = sp_q;
                sp_d     = sp_q + SP_ONE;
                depth_d  = depth_q + DEPTH_ONE;
              end
            end
            OP_REP: begin
              if (empty_q) unf_d = 1'b1;
              else         tos_d = cmd_data;
            end
            OP_POP: begin
              if (empty_q) begin
                unf_d = 1'b1;
              end else if (depth_q == DEPTH_ONE) begin
                tos_d   = '0;
                depth_d = '0;
              end else begin
                state_d = S_RD_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      S_RD_WAIT: state_d = S_RD_LOAD;
      S_RD_LOAD: begin
        tos_d   = rd_q;
        sp_d    = sp_q - SP_ONE;
        depth_d = depth_q - DEPTH_ONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      depth_q <= '0;
      tos_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      tos_q   <= tos_d;
      empty_q <= (depth_d == '0);
      full_q  <= (depth_d == CAP);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Single-port RAM, read-first, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= tos_q;
    rd_q <= mem[mem_addr];
  end

endmodule
